// File: rtl/cbb_arb_pkg.sv
// Shared definitions for the CBB stream arbiters: FSM states, counter width
// and the index-width helper.
package cbb_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  localparam int BEAT_CNT_W = 8;

  // Width needed to index n items, never less than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/cbb_rr_pick.sv
// Combinational round-robin selector: the first request above ptr, wrapping
// around to the lowest request when nothing above ptr is pending.
module cbb_rr_pick #(
  parameter int P_NUM  = 4,
  parameter int P_ID_W = 2
) (
  input  logic [P_NUM-1:0]  req,
  input  logic [P_ID_W-1:0] ptr,
  output logic              found,
  output logic [P_ID_W-1:0] idx
);

  logic [P_NUM-1:0]   mask;
  logic [2*P_NUM-1:0] dbl;
  logic [P_ID_W:0]    sel;

  // Lower half holds requests strictly above ptr, upper half the full vector,
  // so the lowest set bit of the doubled vector is the wrapped winner.
  always_comb begin
    for (int i = 0; i < P_NUM; i++) mask[i] = (P_ID_W'(i) > ptr);
    dbl = {req, req & mask};
    sel = '0;
    for (int i = 2*P_NUM-1; i >= 0; i--) begin
      if (dbl[i]) sel = (P_ID_W+1)'(i);
    end
    found = |req;
    if (sel >= (P_ID_W+1)'(P_NUM)) idx = P_ID_W'(sel - (P_ID_W+1)'(P_NUM));
    else                          idx = sel[P_ID_W-1:0];
  end

endmodule

// File: rtl/cbb_stream_arbiter.sv
// Round-robin valid/ready stream arbiter with burst locking, forced cut at
// P_MAX_BURST beats and a registered, source-tagged output stage.
module cbb_stream_arbiter
  import cbb_arb_pkg::*;
#(
  parameter int    P_NUM_SLV    = 4,
  parameter int    P_DATA_WIDTH = 32,
  parameter int    P_MAX_BURST  = 4,
  localparam int   P_ID_WIDTH   = clog2(P_NUM_SLV)
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [P_NUM_SLV-1:0]            slv_i_valid,
  input  logic [P_NUM_SLV*P_DATA_WIDTH-1:0] slv_i_data,
  input  logic [P_NUM_SLV-1:0]            slv_i_last,
  output logic [P_NUM_SLV-1:0]            slv_o_ready,
  output logic                            mst_o_valid,
  output logic [P_DATA_WIDTH-1:0]         mst_o_data,
  output logic                            mst_o_last,
  output logic [P_ID_WIDTH-1:0]           mst_o_id,
  input  logic                            mst_i_ready
);

  localparam logic [BEAT_CNT_W-1:0] CNT_LAST = BEAT_CNT_W'(P_MAX_BURST - 1);
  localparam logic [P_ID_WIDTH-1:0] PTR_RST  = P_ID_WIDTH'(P_NUM_SLV - 1);

  arb_state_t              state;
  logic [P_ID_WIDTH-1:0]   rr_ptr;
  logic [P_ID_WIDTH-1:0]   grant_id;
  logic [BEAT_CNT_W-1:0]   beat_cnt;
  logic                    pick_found;
  logic [P_ID_WIDTH-1:0]   pick_idx;
  logic                    out_free;
  logic                    accept;
  logic                    beat_last;
  logic [P_DATA_WIDTH-1:0] grant_data;

  cbb_rr_pick #(
    .P_NUM  (P_NUM_SLV),
    .P_ID_W (P_ID_WIDTH)
  ) u_pick (
    .req   (slv_i_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Ready follows output-register space so a beat can load while the
  // previous one drains.
  always_comb begin
    out_free    = ~mst_o_valid | mst_i_ready;
    grant_data  = slv_i_data[grant_id * P_DATA_WIDTH +: P_DATA_WIDTH];
    beat_last   = slv_i_last[grant_id] | (beat_cnt == CNT_LAST);
    slv_o_ready = '0;
    if (state == ST_GRANT) slv_o_ready[grant_id] = out_free;
    accept      = slv_i_valid[grant_id] & slv_o_ready[grant_id];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      rr_ptr      <= PTR_RST;
      grant_id    <= '0;
      beat_cnt    <= '0;
      mst_o_valid <= 1'b0;
      mst_o_data  <= '0;
      mst_o_last  <= 1'b0;
      mst_o_id    <= '0;
    end else begin
      // Output stage: load on accept, otherwise drain when downstream takes it
      if (accept) begin
        mst_o_valid <= 1'b1;
        mst_o_data  <= grant_data;
        mst_o_last  <= beat_last;
        mst_o_id    <= grant_id;
      end else if (mst_i_ready) begin
        mst_o_valid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            grant_id <= pick_idx;
            beat_cnt <= '0;
            state    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // The grant only ends on an accepted last beat, never on a valid gap
          if (accept) begin
            beat_cnt <= beat_cnt + BEAT_CNT_W'(1);
            if (beat_last) begin
              rr_ptr <= grant_id;
              state  <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cbb_stream_arbiter.sv
// Self-checking bench for cbb_stream_arbiter: directed scenarios plus a
// randomized backpressure run checked against per-source expected beat queues.
module tb_cbb_stream_arbiter;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int MB  = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   slv_i_valid;
  logic [N*W-1:0] slv_i_data;
  logic [N-1:0]   slv_i_last;
  logic [N-1:0]   slv_o_ready;
  logic           mst_o_valid;
  logic [W-1:0]   mst_o_data;
  logic           mst_o_last;
  logic [IDW-1:0] mst_o_id;
  logic           mst_i_ready;

  cbb_stream_arbiter #(
    .P_NUM_SLV    (N),
    .P_DATA_WIDTH (W),
    .P_MAX_BURST  (MB)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .slv_i_valid (slv_i_valid),
    .slv_i_data  (slv_i_data),
    .slv_i_last  (slv_i_last),
    .slv_o_ready (slv_o_ready),
    .mst_o_valid (mst_o_valid),
    .mst_o_data  (mst_o_data),
    .mst_o_last  (mst_o_last),
    .mst_o_id    (mst_o_id),
    .mst_i_ready (mst_i_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  typedef struct {
    int           id;
    logic [W-1:0] data;
    logic         last;
    int           cyc;
  } olog_t;

  beat_t src_q [N][$];
  beat_t exp_q [N][$];
  int    seg [N];
  olog_t out_log [$];
  int    ord_id [$];
  bit    ord_last [$];

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int gap_left = 0;
  bit gap_arm  = 1'b0;
  bit gap_watch = 1'b0;
  bit rnd_rdy  = 1'b0;
  int rdy_left = 0;
  bit prev_stall = 1'b0;
  logic [W-1:0]   prev_data;
  logic           prev_last;
  logic [IDW-1:0] prev_id;

  task automatic chk(input string tag, input logic [63:0] obs_v, input logic [63:0] exp_v);
    n_chk++;
    assert (obs_v === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs_v, exp_v);
    end
  endtask

  // Queue a burst; the expected output copy carries a forced last on every
  // MB-th beat of a source since its previous output last.
  task automatic load(input int s, input int n, input logic [W-1:0] base);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.data = base + W'(k);
      b.last = (k == n-1);
      src_q[s].push_back(b);
      if (seg[s] == MB-1) b.last = 1'b1;
      seg[s] = b.last ? 0 : seg[s] + 1;
      exp_q[s].push_back(b);
    end
  endtask

  task automatic flush();
    for (int s = 0; s < N; s++) begin
      src_q[s].delete();
      exp_q[s].delete();
      seg[s] = 0;
    end
    out_log.delete();
  endtask

  task automatic drive();
    for (int s = 0; s < N; s++) begin
      if (src_q[s].size() > 0 && !(s == 0 && gap_left > 0)) begin
        slv_i_valid[s]         = 1'b1;
        slv_i_data[s*W +: W]   = src_q[s][0].data;
        slv_i_last[s]          = src_q[s][0].last;
      end else begin
        slv_i_valid[s]         = 1'b0;
        slv_i_data[s*W +: W]   = $urandom;
        slv_i_last[s]          = 1'b0;
      end
    end
  endtask

  task automatic obs();
    olog_t o;
    beat_t e;
    @(negedge clk);
    chk("rdy_onehot0", 64'($onehot0(slv_o_ready)), 64'(1));
    if (rst) begin
      prev_stall = 1'b0;
      return;
    end
    if (gap_watch && src_q[0].size() > 0) chk("gap_rdy1", 64'(slv_o_ready[1]), 64'(0));
    if (mst_o_valid && !mst_i_ready) chk("bp_ready", 64'(slv_o_ready), 64'(0));
    if (prev_stall) begin
      chk("stall_valid", 64'(mst_o_valid), 64'(1));
      chk("stall_data",  64'(mst_o_data),  64'(prev_data));
      chk("stall_last",  64'(mst_o_last),  64'(prev_last));
      chk("stall_id",    64'(mst_o_id),    64'(prev_id));
    end
    for (int s = 0; s < N; s++) begin
      if (slv_o_ready[s] && slv_i_valid[s]) begin
        void'(src_q[s].pop_front());
        if (s == 0 && gap_arm) begin
          gap_arm  = 1'b0;
          gap_left = 5;
        end
      end
    end
    if (mst_o_valid && mst_i_ready) begin
      n_chk++;
      assert (exp_q[mst_o_id].size() > 0) else begin
        n_err++;
        $error("FAIL extra_beat id=%0d observed=0x%0h expected=no beat", mst_o_id, mst_o_data);
      end
      if (exp_q[mst_o_id].size() > 0) begin
        e = exp_q[mst_o_id].pop_front();
        chk("beat_data", 64'(mst_o_data), 64'(e.data));
        chk("beat_last", 64'(mst_o_last), 64'(e.last));
      end
      o.id = int'(mst_o_id);
      o.data = mst_o_data;
      o.last = mst_o_last;
      o.cyc  = cyc;
      out_log.push_back(o);
    end
    prev_stall = mst_o_valid && !mst_i_ready;
    prev_data  = mst_o_data;
    prev_last  = mst_o_last;
    prev_id    = mst_o_id;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    cyc++;
    if (rnd_rdy) begin
      if (rdy_left == 0) begin
        mst_i_ready = ~mst_i_ready;
        rdy_left    = int'($urandom_range(1, 10));
      end
      rdy_left--;
    end
    drive();
    if (gap_left > 0) gap_left--;
  endtask

  task automatic tick();
    obs();
    adv();
  endtask

  function automatic bit idle_all();
    for (int s = 0; s < N; s++) begin
      if (src_q[s].size() > 0 || exp_q[s].size() > 0) return 1'b0;
    end
    return !mst_o_valid;
  endfunction

  task automatic drain(input string tag, input int budget);
    int k;
    k = 0;
    while (!idle_all() && k < budget) begin
      tick();
      k++;
    end
    chk({tag, "_drained"}, 64'(idle_all()), 64'(1));
  endtask

  task automatic expect_beat(input int id, input bit last);
    ord_id.push_back(id);
    ord_last.push_back(last);
  endtask

  task automatic check_order(input string tag);
    chk({tag, "_count"}, 64'(out_log.size()), 64'(ord_id.size()));
    for (int i = 0; i < ord_id.size() && i < out_log.size(); i++) begin
      chk({tag, "_id"},   64'(out_log[i].id),   64'(ord_id[i]));
      chk({tag, "_last"}, 64'(out_log[i].last), 64'(ord_last[i]));
    end
    ord_id.delete();
    ord_last.delete();
  endtask

  initial begin
    int t0;
    int k;
    mst_i_ready = 1'b1;
    slv_i_valid = '0;
    slv_i_data  = '0;
    slv_i_last  = '0;
    for (int s = 0; s < N; s++) seg[s] = 0;
    rst = 1'b1;
    drive();
    repeat (3) tick();
    obs();
    chk("rst_valid", 64'(mst_o_valid), 64'(0));
    chk("rst_data",  64'(mst_o_data),  64'(0));
    chk("rst_last",  64'(mst_o_last),  64'(0));
    chk("rst_id",    64'(mst_o_id),    64'(0));
    chk("rst_ready", 64'(slv_o_ready), 64'(0));
    adv();
    rst = 1'b0;

    // All four requesters with single-beat bursts: strict rotation from 0
    out_log.delete();
    for (int r = 0; r < 3; r++)
      for (int s = 0; s < N; s++) load(s, 1, W'(32'h100 * (s + 1) + r));
    drive();
    drain("t2", 300);
    for (int i = 0; i < 12; i++) expect_beat(i % N, 1'b1);
    check_order("t2");
    for (int i = 1; i < out_log.size(); i++)
      chk("t2_bubble", 64'(out_log[i].cyc - out_log[i-1].cyc), 64'(2));

    // Single requester burst: latency and back-to-back beats
    out_log.delete();
    load(2, 3, 32'hA0);
    drive();
    t0 = cyc;
    drain("t1", 50);
    chk("t1_count", 64'(out_log.size()), 64'(3));
    for (int i = 0; i < out_log.size(); i++) begin
      chk("t1_id",   64'(out_log[i].id),   64'(2));
      chk("t1_data", 64'(out_log[i].data), 64'(32'hA0 + i));
      chk("t1_last", 64'(out_log[i].last), 64'(i == 2));
      chk("t1_cyc",  64'(out_log[i].cyc),  64'(t0 + 2 + i));
    end

    // Burst cut: slv 1 six beats, slv 3 joins once slv 1 holds the grant
    out_log.delete();
    load(1, 6, 32'h10);
    drive();
    tick();
    load(3, 2, 32'h30);
    drive();
    drain("t3", 100);
    for (int i = 0; i < 4; i++) expect_beat(1, i == 3);
    expect_beat(3, 1'b0);
    expect_beat(3, 1'b1);
    expect_beat(1, 1'b0);
    expect_beat(1, 1'b1);
    check_order("t3");

    // Randomized bursts under random downstream backpressure
    out_log.delete();
    rnd_rdy  = 1'b1;
    rdy_left = 0;
    load(0, 4, 32'hC0);
    for (int b = 0; b < 20; b++)
      load(int'($urandom_range(0, N-1)), int'($urandom_range(1, 6)), $urandom);
    drive();
    drain("t4", 5000);
    rnd_rdy     = 1'b0;
    mst_i_ready = 1'b1;
    drive();

    // Valid gap on the granted requester: grant must hold
    out_log.delete();
    gap_arm = 1'b1;
    load(0, 3, 32'h50);
    drive();
    tick();
    load(1, 1, 32'h60);
    gap_watch = 1'b1;
    drive();
    drain("t5", 100);
    gap_watch = 1'b0;
    for (int i = 0; i < 3; i++) expect_beat(0, i == 2);
    expect_beat(1, 1'b1);
    check_order("t5");

    // Reset during beat 2 of 4
    out_log.delete();
    load(2, 4, 32'h70);
    drive();
    k = 0;
    while (src_q[2].size() > 3 && k < 20) begin
      tick();
      k++;
    end
    chk("t6_beat1_taken", 64'(src_q[2].size()), 64'(3));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    flush();
    load(0, 1, 32'h80);
    load(2, 1, 32'h90);
    drive();
    obs();
    chk("t6_valid", 64'(mst_o_valid), 64'(0));
    chk("t6_ready", 64'(slv_o_ready), 64'(0));
    chk("t6_data",  64'(mst_o_data),  64'(0));
    chk("t6_last",  64'(mst_o_last),  64'(0));
    chk("t6_id",    64'(mst_o_id),    64'(0));
    adv();
    drain("t6", 100);
    expect_beat(0, 1'b1);
    expect_beat(2, 1'b1);
    check_order("t6");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/cbb_stream_arbiter.md
# cbb_stream_arbiter

Round-robin arbiter that shares one valid/ready stream channel between P_NUM_SLV requesters, with burst locking and a registered output stage. Sits in front of a shared downstream channel (e.g. a backward register slice or a shared FIFO write port): each requester presents a valid/ready/data/last stream, and the arbiter forwards one requester's burst at a time, tagging every beat with the source index.

## Interface
- P_NUM_SLV, 4: number of requesters, 2..16.
- P_DATA_WIDTH, 32: data width per beat.
- P_MAX_BURST, 4: maximum beats per grant before forced re-arbitration, 1..255.
- P_ID_WIDTH, clog2(P_NUM_SLV): derived width of the source index; not overridden.
- i_clk  in  1  clock; all logic is on the rising edge.
- i_rst  in  1  reset; synchronous, active-high.
- slv_i_valid  in  P_NUM_SLV  per-requester valid.
- slv_i_data  in  P_NUM_SLV*P_DATA_WIDTH  per-requester data; requester k occupies bits [k*W +: W].
- slv_i_last  in  P_NUM_SLV  per-requester end-of-burst flag.
- slv_o_ready  out  P_NUM_SLV  per-requester ready; one-hot or zero.
- mst_o_valid  out  1  output beat valid (registered).
- mst_o_data  out  P_DATA_WIDTH  output data (registered).
- mst_o_last  out  1  output last; also set on a forced P_MAX_BURST cut.
- mst_o_id  out  P_ID_WIDTH  source index of the current output beat.
- mst_i_ready  in  1  downstream ready.

## Operation
- Two states, encoded in the package: ST_IDLE and ST_GRANT.
- ST_IDLE:
  - slv_o_ready is all zero.
  - If any slv_i_valid bit is set, select the first set bit searching upward (with wrap) from rr_ptr+1.
  - Latch the selected index into grant_id, clear beat_cnt, and go to ST_GRANT.
  - If no slv_i_valid bit is set, stay in ST_IDLE.
- ST_GRANT:
  - slv_o_ready[grant_id] = out_free, where out_free = ~mst_o_valid | mst_i_ready. All other ready bits are 0.
- Accept: slv_i_valid[grant_id] & slv_o_ready[grant_id]. On an accept, all of the following happen in the same cycle:
  - The output register loads the granted requester's data, with last = slv_i_last | (beat_cnt == P_MAX_BURST-1), and id = grant_id.
  - beat_cnt increments.
  - If that beat's last is 1: rr_ptr <= grant_id and the state goes to ST_IDLE.
- Output register: if mst_i_ready is high and there is no accept in the same cycle, mst_o_valid clears. Load and drain in the same cycle are allowed, which gives full throughput inside a burst.
- Grant lock: the grant is never revoked mid-burst, except by reset. If the granted requester drops valid, the arbiter waits in ST_GRANT. Upstream holds valid and data stable until accepted.
- Requesters that are not granted see ready=0 and hold their data; the arbiter never drops a beat.
- rr_ptr wraps modulo P_NUM_SLV. For P_NUM_SLV that is not a power of two, indices ≥ P_NUM_SLV are never selected.

## Timing
- Reset values:
  - Outputs: mst_o_valid=0, mst_o_data=0, mst_o_last=0, mst_o_id=0, slv_o_ready=0.
  - Internal: state=ST_IDLE, rr_ptr=P_NUM_SLV-1 (so requester 0 wins first), beat_cnt=0, grant_id=0.
- Arbitration takes 1 cycle: a valid request first seen in cycle t gives slv_o_ready high in cycle t+1, provided out_free is high.
- Accept-to-output latency is 1 cycle: a beat accepted in cycle t shows on mst_o_* in cycle t+1.
- Burst throughput is 1 beat per cycle while mst_i_ready=1. There is exactly one bubble cycle (ST_IDLE) between consecutive grants.
- Downstream backpressure: with mst_o_valid=1 and mst_i_ready=0, ready to the granted requester is 0 and mst_o_* hold stable.
- If last and the beat_cnt limit coincide on the same beat, a single last is output.
- Reset in the middle of a burst: in the next cycle all outputs take their reset values. Any beat held in the output register is discarded, and rr_ptr returns to P_NUM_SLV-1.

## Structure
- Package cbb_arb_pkg holds:
  - the state localparams ST_IDLE and ST_GRANT;
  - a clog2 function for P_ID_WIDTH;
  - the beat_cnt width constant (8 bits).
- Sub-module cbb_rr_pick:
  - Combinational round-robin selector.
  - Inputs: request vector and rr_ptr. Outputs: found flag and selected index.
  - Implemented as a double-width masked priority encode.
  - Reusable by other arbiters in the CBB library.
- Top level: the state machine, beat counter, and output register.

## Test plan
- Single requester: slv 2 sends a 3-beat burst 0xA0, 0xA1, 0xA2 (last on 0xA2) with mst_i_ready=1. Expected: mst_o_id=2 and the data in order, last only on 0xA2, back-to-back beats, first output 2 cycles after valid.
- All 4 requesters request continuously with 1-beat bursts. Expected: grant order 0,1,2,3,0,1…, one bubble between grants.
- Burst cut: P_MAX_BURST=4, slv 1 sends 6 beats with last on beat 6, slv 3 also requesting. Expected: beats 1-4 with last forced on beat 4, then slv 3's burst, then slv 1 beats 5-6.
- Backpressure: toggle mst_i_ready randomly (1-10 cycles per phase) over 20 bursts from 4 random sources. Expected: the output log equals the input log per source, with no loss, duplication, or reordering within a source, and mst_o_* stable while stalled.
- Valid gap: the granted slv 0 drops valid for 5 cycles mid-burst while slv 1 requests. Expected: the grant stays on slv 0, and slv_o_ready[1] stays 0 until slv 0's last is accepted.
- Reset mid-burst: assert i_rst for 1 cycle during beat 2 of 4. Expected: next cycle mst_o_valid=0 and slv_o_ready=0; after reset, requester 0 wins first.
